// File: rtl/pong_game_ctrl.sv
// Match sequencer for Pong: walks START -> SERVE -> PLAY -> DONE, counts points
// from the ball status and declares a winner at WIN_SCORE.
module pong_game_ctrl #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic [1:0] ball_status,
  output logic [1:0] state,
  output logic       serve,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic       point
);

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_SERVE = 2'b01,
    ST_PLAY  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [3:0]  WIN_PTS  = 4'(WIN_SCORE);
  localparam logic [26:0] CNT_LAST = 27'(SERVE_DELAY - 1);

  localparam logic [1:0] BS_P1  = 2'b01;
  localparam logic [1:0] BS_P2  = 2'b10;
  localparam logic [1:0] WIN_P1 = 2'b01;
  localparam logic [1:0] WIN_P2 = 2'b10;

  state_t      state_q, state_d;
  logic        serve_q, serve_d;
  logic [3:0]  score1_q, score1_d;
  logic [3:0]  score2_q, score2_d;
  logic [1:0]  winner_q, winner_d;
  logic        point_q, point_d;
  logic [26:0] cnt_q, cnt_d;
  logic        start_prev;
  logic        start_edge;
  logic [3:0]  score1_inc;
  logic [3:0]  score2_inc;

  // start_prev resets high so a button held through reset never starts a game.
  assign start_edge = start_btn & ~start_prev;
  assign score1_inc = score1_q + 4'd1;
  assign score2_inc = score2_q + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_START;
      serve_q    <= 1'b0;
      score1_q   <= 4'd0;
      score2_q   <= 4'd0;
      winner_q   <= 2'b00;
      point_q    <= 1'b0;
      cnt_q      <= 27'd0;
      start_prev <= 1'b1;
    end else begin
      state_q    <= state_d;
      serve_q    <= serve_d;
      score1_q   <= score1_d;
      score2_q   <= score2_d;
      winner_q   <= winner_d;
      point_q    <= point_d;
      cnt_q      <= cnt_d;
      start_prev <= start_btn;
    end
  end

  always_comb begin
    state_d  = state_q;
    serve_d  = serve_q;
    score1_d = score1_q;
    score2_d = score2_q;
    winner_d = winner_q;
    point_d  = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      ST_START, ST_DONE: begin
        if (start_edge) begin
          state_d  = ST_SERVE;
          serve_d  = 1'b0;
          score1_d = 4'd0;
          score2_d = 4'd0;
          winner_d = 2'b00;
          cnt_d    = 27'd0;
        end
      end
      ST_SERVE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_PLAY;
          cnt_d   = 27'd0;
        end else begin
          cnt_d = cnt_q + 27'd1;
        end
      end
      ST_PLAY: begin
        // Leaving PLAY on the scoring edge keeps a lingering status from counting twice.
        if (ball_status == BS_P1) begin
          score1_d = score1_inc;
          point_d  = 1'b1;
          serve_d  = 1'b1;
          cnt_d    = 27'd0;
          if (score1_inc == WIN_PTS) begin
            state_d  = ST_DONE;
            winner_d = WIN_P1;
          end else begin
            state_d = ST_SERVE;
          end
        end else if (ball_status == BS_P2) begin
          score2_d = score2_inc;
          point_d  = 1'b1;
          serve_d  = 1'b0;
          cnt_d    = 27'd0;
          if (score2_inc == WIN_PTS) begin
            state_d  = ST_DONE;
            winner_d = WIN_P2;
          end else begin
            state_d = ST_SERVE;
          end
        end
      end
      default: state_d = ST_START;
    endcase
  end

  assign state  = state_q;
  assign serve  = serve_q;
  assign score1 = score1_q;
  assign score2 = score2_q;
  assign winner = winner_q;
  assign point  = point_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with WIN_SCORE=3, SERVE_DELAY=4: a cycle
// table covering start, serve delay, scoring and win, plus an async-reset sequence.
module tb_pong_game_ctrl;

  logic       clk;
  logic       rst;
  logic       start_btn;
  logic [1:0] ball_status;
  logic [1:0] state;
  logic       serve;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] winner;
  logic       point;

  int total;
  int bad;

  pong_game_ctrl #(.WIN_SCORE(3), .SERVE_DELAY(4)) dut (
    .clk(clk),
    .rst(rst),
    .start_btn(start_btn),
    .ball_status(ball_status),
    .state(state),
    .serve(serve),
    .score1(score1),
    .score2(score2),
    .winner(winner),
    .point(point)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       btn;
    logic [1:0] bs;
    logic [1:0] st;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] win;
    logic       srv;
    logic       pt;
  } vec_t;

  vec_t vecs[30];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [3:0] s1,
                           input logic [3:0] s2, input logic [1:0] win, input logic srv,
                           input logic pt);
    check({tag, ".state"},  int'(state),  int'(st));
    check({tag, ".score1"}, int'(score1), int'(s1));
    check({tag, ".score2"}, int'(score2), int'(s2));
    check({tag, ".winner"}, int'(winner), int'(win));
    check({tag, ".serve"},  int'(serve),  int'(srv));
    check({tag, ".point"},  int'(point),  int'(pt));
  endtask

  task automatic step(input logic btn, input logic [1:0] bs);
    @(negedge clk);
    start_btn   = btn;
    ball_status = bs;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_play(input string tag);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (state == 2'b10) begin
        seen = 1;
        break;
      end
      step(1'b0, 2'b00);
    end
    check({tag, ".reach_play"}, int'(seen), 1);
  endtask

  function automatic vec_t mk(input logic btn, input logic [1:0] bs, input logic [1:0] st,
                              input logic [3:0] s1, input logic [3:0] s2,
                              input logic [1:0] win, input logic srv, input logic pt);
    vec_t v;
    v.btn = btn; v.bs = bs; v.st = st; v.s1 = s1; v.s2 = s2;
    v.win = win; v.srv = srv; v.pt = pt;
    return v;
  endfunction

  initial begin
    total = 0;
    bad   = 0;

    //              btn   bs     state  s1 s2 win  srv pt
    vecs[0]  = mk(1'b1, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0); // held through reset
    vecs[1]  = mk(1'b1, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0);
    vecs[2]  = mk(1'b0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0);
    vecs[3]  = mk(1'b1, 2'b00, 2'b01, 0, 0, 2'b00, 0, 0); // press -> SERVE
    vecs[4]  = mk(1'b1, 2'b00, 2'b01, 0, 0, 2'b00, 0, 0);
    vecs[5]  = mk(1'b0, 2'b01, 2'b01, 0, 0, 2'b00, 0, 0); // status ignored in SERVE
    vecs[6]  = mk(1'b1, 2'b10, 2'b01, 0, 0, 2'b00, 0, 0); // press ignored in SERVE
    vecs[7]  = mk(1'b1, 2'b00, 2'b10, 0, 0, 2'b00, 0, 0); // 4 SERVE cycles then PLAY
    vecs[8]  = mk(1'b0, 2'b11, 2'b10, 0, 0, 2'b00, 0, 0); // reserved status
    vecs[9]  = mk(1'b1, 2'b00, 2'b10, 0, 0, 2'b00, 0, 0); // press ignored in PLAY
    vecs[10] = mk(1'b0, 2'b01, 2'b01, 1, 0, 2'b00, 1, 1); // p1 scores
    vecs[11] = mk(1'b0, 2'b01, 2'b01, 1, 0, 2'b00, 1, 0); // status persists
    vecs[12] = mk(1'b0, 2'b01, 2'b01, 1, 0, 2'b00, 1, 0);
    vecs[13] = mk(1'b0, 2'b00, 2'b01, 1, 0, 2'b00, 1, 0);
    vecs[14] = mk(1'b0, 2'b00, 2'b10, 1, 0, 2'b00, 1, 0);
    vecs[15] = mk(1'b0, 2'b10, 2'b01, 1, 1, 2'b00, 0, 1); // p2 scores
    vecs[16] = mk(1'b0, 2'b00, 2'b01, 1, 1, 2'b00, 0, 0);
    vecs[17] = mk(1'b0, 2'b00, 2'b01, 1, 1, 2'b00, 0, 0);
    vecs[18] = mk(1'b0, 2'b00, 2'b01, 1, 1, 2'b00, 0, 0);
    vecs[19] = mk(1'b0, 2'b00, 2'b10, 1, 1, 2'b00, 0, 0);
    vecs[20] = mk(1'b0, 2'b10, 2'b01, 1, 2, 2'b00, 0, 1);
    vecs[21] = mk(1'b0, 2'b00, 2'b01, 1, 2, 2'b00, 0, 0);
    vecs[22] = mk(1'b0, 2'b00, 2'b01, 1, 2, 2'b00, 0, 0);
    vecs[23] = mk(1'b0, 2'b00, 2'b01, 1, 2, 2'b00, 0, 0);
    vecs[24] = mk(1'b0, 2'b00, 2'b10, 1, 2, 2'b00, 0, 0);
    vecs[25] = mk(1'b0, 2'b10, 2'b11, 1, 3, 2'b10, 0, 1); // p2 wins
    vecs[26] = mk(1'b0, 2'b01, 2'b11, 1, 3, 2'b10, 0, 0); // DONE holds
    vecs[27] = mk(1'b0, 2'b10, 2'b11, 1, 3, 2'b10, 0, 0);
    vecs[28] = mk(1'b1, 2'b00, 2'b01, 0, 0, 2'b00, 0, 0); // restart clears
    vecs[29] = mk(1'b1, 2'b00, 2'b01, 0, 0, 2'b00, 0, 0);

    rst         = 1'b1;
    start_btn   = 1'b1;
    ball_status = 2'b00;
    #3;
    check_all("reset", 2'b00, 0, 0, 2'b00, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 30; i++) begin
      step(vecs[i].btn, vecs[i].bs);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].s1, vecs[i].s2,
                vecs[i].win, vecs[i].srv, vecs[i].pt);
    end

    // Two player-1 points, then async reset in the middle of PLAY.
    for (int p = 1; p <= 2; p++) begin
      wait_play($sformatf("p1pt%0d", p));
      step(1'b0, 2'b01);
      check_all($sformatf("p1pt%0d", p), 2'b01, 4'(p), 0, 2'b00, 1, 1);
    end
    wait_play("pre_rst");
    check("pre_rst.score1", int'(score1), 2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all("async_rst", 2'b00, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 2'b00);
    check_all("post_rst", 2'b00, 0, 0, 2'b00, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
